// File: rtl/sw_array_feeder.sv
// rtl/sw_array_feeder.sv - Loads the query into a systolic PE chain, streams reference bases, then drains it.
module sw_array_feeder #(
    parameter int WIDTH  = 10,
    parameter int NUM_PE = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] threshold_in,
    input  logic             q_valid,
    input  logic [1:0]       q_data,
    output logic             q_ready,
    input  logic             r_valid,
    input  logic [1:0]       r_data,
    input  logic             r_last,
    output logic             r_ready,
    input  logic             stall_in,
    output logic             stall_out,
    output logic [1:0]       S_out,
    output logic             store_S_out,
    output logic [1:0]       T_out,
    output logic             init_out,
    output logic [WIDTH-1:0] V_out,
    output logic [WIDTH-1:0] F_out,
    output logic [WIDTH-1:0] cell_score_threshold_out,
    output logic [31:0]      ref_count,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(NUM_PE + 1);
    localparam logic [CW-1:0] NUM_PE_C = CW'(NUM_PE);
    localparam logic [CW-1:0] LAST_Q   = CW'(NUM_PE - 1);
    // Most negative score that still leaves headroom for gap penalties.
    localparam logic [WIDTH-1:0] F_MIN = {2'b11, {(WIDTH-2){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, FINISH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] thr_q, thr_d;
    logic [CW-1:0]    load_cnt_q, load_cnt_d;
    logic [CW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [1:0]       s_q, s_d;
    logic             store_q, store_d;
    logic [1:0]       t_q, t_d;
    logic             init_q, init_d;
    logic             stall_q, stall_d;
    logic [31:0]      ref_q, ref_d;
    logic             q_acc, r_acc;

    assign q_ready = (state_q == LOAD) && !stall_in;
    assign r_ready = (state_q == STREAM) && !stall_in;
    assign q_acc   = q_valid && q_ready;
    assign r_acc   = r_valid && r_ready;

    always_comb begin
        state_d     = state_q;
        thr_d       = thr_q;
        load_cnt_d  = load_cnt_q;
        drain_cnt_d = drain_cnt_q;
        s_d         = s_q;
        store_d     = 1'b0;
        t_d         = t_q;
        init_d      = init_q;
        ref_d       = ref_q;
        stall_d     = stall_in;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    thr_d      = threshold_in;
                    ref_d      = '0;
                    load_cnt_d = '0;
                end
            end
            LOAD: begin
                if (q_acc) begin
                    s_d        = q_data;
                    store_d    = 1'b1;
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == LAST_Q) state_d = STREAM;
                end
            end
            STREAM: begin
                if (r_acc) begin
                    t_d    = r_data;
                    init_d = 1'b1;
                    if (ref_q != '1) ref_d = ref_q + 32'd1;
                    if (r_last) begin
                        state_d     = DRAIN;
                        drain_cnt_d = NUM_PE_C;
                    end
                end else begin
                    // Bubble: T/init hold while the whole chain is frozen.
                    stall_d = 1'b1;
                end
            end
            DRAIN: begin
                if (!stall_in) begin
                    init_d      = 1'b0;
                    t_d         = 2'd0;
                    drain_cnt_d = drain_cnt_q - 1'b1;
                    if (drain_cnt_q == CW'(1)) state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            thr_q       <= '0;
            load_cnt_q  <= '0;
            drain_cnt_q <= '0;
            s_q         <= '0;
            store_q     <= 1'b0;
            t_q         <= '0;
            init_q      <= 1'b0;
            stall_q     <= 1'b0;
            ref_q       <= '0;
        end else begin
            state_q     <= state_d;
            thr_q       <= thr_d;
            load_cnt_q  <= load_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            s_q         <= s_d;
            store_q     <= store_d;
            t_q         <= t_d;
            init_q      <= init_d;
            stall_q     <= stall_d;
            ref_q       <= ref_d;
        end
    end

    assign stall_out                = stall_q;
    assign S_out                    = s_q;
    assign store_S_out              = store_q;
    assign T_out                    = t_q;
    assign init_out                 = init_q;
    assign V_out                    = '0;
    assign F_out                    = F_MIN;
    assign cell_score_threshold_out = thr_q;
    assign ref_count                = ref_q;
    assign busy                     = (state_q != IDLE);
    assign done                     = (state_q == FINISH);

endmodule

// File: tb/tb_sw_array_feeder.sv
// tb/tb_sw_array_feeder.sv - Scoreboard bench for sw_array_feeder with NUM_PE=4.
module tb_sw_array_feeder;
    localparam int W = 10;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst, start, q_valid, r_valid, r_last, stall_in;
    logic [W-1:0] threshold_in;
    logic [1:0]   q_data, r_data;
    logic         q_ready, r_ready, stall_out, store_S_out, init_out, busy, done;
    logic [1:0]   S_out, T_out;
    logic [W-1:0] V_out, F_out, thr_out;
    logic [31:0]  ref_count;

    sw_array_feeder #(.WIDTH(W), .NUM_PE(N)) dut (
        .clk(clk), .rst(rst), .start(start), .threshold_in(threshold_in),
        .q_valid(q_valid), .q_data(q_data), .q_ready(q_ready),
        .r_valid(r_valid), .r_data(r_data), .r_last(r_last), .r_ready(r_ready),
        .stall_in(stall_in), .stall_out(stall_out),
        .S_out(S_out), .store_S_out(store_S_out), .T_out(T_out), .init_out(init_out),
        .V_out(V_out), .F_out(F_out), .cell_score_threshold_out(thr_out),
        .ref_count(ref_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] exp_s[$];
    logic [1:0] exp_t[$];
    int cyc = 0, last_init_cyc = 0, done_cyc = 0, done_cnt = 0;
    int store_cnt = 0, store_run = 0, max_run = 0, stall_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard whenever the PE chain sees a new base.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            store_run = store_S_out ? store_run + 1 : 0;
            if (store_run > max_run) max_run = store_run;
            if (stall_out) stall_cnt++;
            if (store_S_out) begin
                store_cnt++;
                check_eq("store_init_excl", {31'd0, init_out}, 0);
                check_eq("s_pending", exp_s.size() > 0, 1);
                if (exp_s.size() > 0) check_eq("S_out", S_out, exp_s.pop_front());
            end
            if (init_out && !stall_out) begin
                last_init_cyc = cyc;
                check_eq("t_pending", exp_t.size() > 0, 1);
                if (exp_t.size() > 0) check_eq("T_out", T_out, exp_t.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send_q(input logic [1:0] d);
        bit ok = 0;
        q_valid = 1'b1;
        q_data  = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (q_ready) begin
                exp_s.push_back(d);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check_eq("q_accept_timeout", q_ready, 1);
        q_valid = 1'b0;
    endtask

    task automatic send_r(input logic [1:0] d, input logic last);
        bit ok = 0;
        r_valid = 1'b1;
        r_data  = d;
        r_last  = last;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (r_ready) begin
                exp_t.push_back(d);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check_eq("r_accept_timeout", r_ready, 1);
        r_valid = 1'b0;
        r_last  = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check_eq("done_seen", seen, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic begin_align(input logic [W-1:0] thr);
        start = 1'b1;
        threshold_in = thr;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        check_eq("thr_latched", thr_out, thr);
    endtask

    int snap;

    initial begin
        rst = 1'b1; start = 0; threshold_in = 0; q_valid = 0; q_data = 0;
        r_valid = 0; r_data = 0; r_last = 0; stall_in = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_store", store_S_out, 0);
        check_eq("rst_init", init_out, 0);
        check_eq("rst_ref", ref_count, 0);
        check_eq("rst_thr", thr_out, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_qready", q_ready, 0);
        check_eq("V_out", V_out, 0);
        check_eq("F_out", F_out, 10'd768);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Alignment 1: plain load, 3-base reference, unstalled drain.
        begin_align(10'd12);
        for (int i = 0; i < 4; i++) send_q(2'(i));
        send_r(2'd1, 1'b0);
        send_r(2'd2, 1'b0);
        send_r(2'd3, 1'b1);
        check_eq("ref_count_a1", ref_count, 3);
        wait_done();
        check_eq("drain_lat_a1", done_cyc - last_init_cyc, 4);
        check_eq("done_cnt_a1", done_cnt, 1);
        check_eq("store_cnt_a1", store_cnt, 4);
        check_eq("store_run_a1", max_run, 4);
        check_eq("busy_idle_a1", busy, 0);

        // Alignment 2: load stall, ignored start, reference gap, drain stall.
        begin_align(10'd7);
        start = 1'b1;
        threshold_in = 10'd5;
        stall_in = 1'b1;
        @(posedge clk);
        #1;
        stall_in = 1'b0;
        send_q(2'd3);
        send_q(2'd2);
        send_q(2'd1);
        start = 1'b0;
        send_q(2'd0);
        check_eq("thr_ignored_start", thr_out, 7);
        send_r(2'd2, 1'b0);
        send_r(2'd1, 1'b0);
        snap = stall_cnt;
        @(negedge clk);
        check_eq("no_stall_after_acc", stall_out, 0);
        @(negedge clk);
        check_eq("gap_stall", stall_out, 1);
        check_eq("gap_T_held", T_out, 1);
        check_eq("gap_init_held", init_out, 1);
        check_eq("gap_ref_held", ref_count, 2);
        @(posedge clk);
        #1;
        send_r(2'd0, 1'b1);
        check_eq("gap_stall_cycles", stall_cnt - snap, 2);
        stall_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("drain_stall_out", stall_out, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        stall_in = 1'b0;
        wait_done();
        check_eq("drain_lat_a2", done_cyc - last_init_cyc, 7);
        check_eq("done_cnt_a2", done_cnt, 2);
        check_eq("ref_count_a2", ref_count, 3);
        check_eq("thr_a2", thr_out, 7);

        // Alignment 3: reset in the middle of the reference stream.
        begin_align(10'd9);
        for (int i = 0; i < 4; i++) send_q(2'(3 - i));
        send_r(2'd2, 1'b0);
        send_r(2'd3, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_init", init_out, 0);
        check_eq("abort_ref", ref_count, 0);
        check_eq("abort_thr", thr_out, 0);
        check_eq("abort_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_s.delete();
        exp_t.delete();
        snap = done_cnt;
        repeat (10) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_cnt, snap);
        check_eq("abort_idle", busy, 0);
        check_eq("t_queue_empty", exp_t.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sw_array_feeder.md
SW_ARRAY_FEEDER -- requirements
Module: sw_array_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 10: score width, matching the PE chain.
REQ-002 SHALL have parameter NUM_PE, default 64: number of PEs in the driven chain, which equals the query length (1..1024).
REQ-003 SHALL use one clock; reset is asynchronous and active-high; ports clk and rst.
REQ-004 Ports, in this order:
 clk  in  1  system clock
 rst  in  1  async active-high reset
 start  in  1  begin one alignment; sampled in IDLE only
 threshold_in  in  WIDTH  cell score threshold; latched on accepted start
 q_valid  in  1  query base valid
 q_data  in  2  query base
 q_ready  out  1  query base accepted when q_valid&q_ready
 r_valid  in  1  reference base valid
 r_data  in  2  reference base
 r_last  in  1  final reference base
 r_ready  out  1  reference base accepted when r_valid&r_ready
 stall_in  in  1  downstream backpressure (result path full)
 stall_out  out  1  PE chain stall
 S_out  out  2  query base to PE 0
 store_S_out  out  1  query store strobe to PE 0
 T_out  out  2  reference base to PE 0
 init_out  out  1  computation active to PE 0
 V_out  out  WIDTH  top-row score to PE 0
 F_out  out  WIDTH  top-row up-gap to PE 0
 cell_score_threshold_out  out  WIDTH  threshold to PE 0
 ref_count  out  32  reference bases issued this alignment
 busy  out  1  not IDLE
 done  out  1  one-cycle completion pulse

Function
REQ-005 SHALL implement states IDLE, LOAD, STREAM, DRAIN, FINISH.
REQ-006 IDLE: start=1 -> LOAD next cycle; latch threshold_in; clear ref_count. start outside IDLE SHALL be ignored.
REQ-007 LOAD: q_ready = !stall_in; each accepted base SHALL drive S_out=q_data, store_S_out=1 on the next cycle; otherwise store_S_out=0.
REQ-008 LOAD SHALL accept exactly NUM_PE bases, then go to STREAM; q_ready=0 in all other states.
REQ-009 STREAM: r_ready = !stall_in; an accepted base SHALL register T_out=r_data, init_out=1 next cycle and increment ref_count.
REQ-010 STREAM with r_valid=0 or stall_in=1: next cycle stall_out=1, T_out and init_out hold prior values (bubble, array frozen).
REQ-011 Accepted base with r_last=1 -> DRAIN; drain counter loads NUM_PE.
REQ-012 DRAIN: each non-stalled cycle drives init_out=0, T_out=0 and decrements the counter; stall_in=1 holds counter and outputs, stall_out=1.
REQ-013 Counter reaching 0 -> FINISH; FINISH drives done=1 for exactly one cycle -> IDLE.
REQ-014 stall_out SHALL be registered: 1 when stall_in or (STREAM and no accepted base) in the prior cycle, else 0; in IDLE, LOAD and DRAIN only stall_in contributes.
REQ-015 V_out SHALL be constant 0; F_out SHALL be constant -(2^(WIDTH-2)) so that adding gap penalties cannot wrap.
REQ-016 cell_score_threshold_out SHALL equal the latched threshold from the cycle after start onward.
REQ-017 ref_count SHALL saturate at 2^32-1.
REQ-018 store_S_out and init_out SHALL never be 1 in the same cycle.
REQ-019 busy SHALL be 1 in LOAD, STREAM, DRAIN and FINISH.

Reset
REQ-020 rst=1 SHALL immediately force IDLE; all outputs 0 except F_out (constant); threshold cleared.
REQ-021 Reset mid-LOAD/STREAM/DRAIN SHALL abort with no done pulse; partially consumed streams are not replayed.

Verification
REQ-022 NUM_PE=4; start, threshold=12; query 0,1,2,3 back-to-back -> store_S_out=1 for 4 consecutive cycles, S_out=0,1,2,3; threshold_out=12.
REQ-023 Reference 3 bases, r_last on 3rd, no stalls -> init_out=1 for 3 cycles, T_out matches, ref_count=3, 4 drain cycles, done one cycle later.
REQ-024 r_valid drops 2 cycles mid-STREAM -> stall_out=1 for those 2 cycles, T_out/init_out held, ref_count unchanged.
REQ-025 stall_in=1 for 3 cycles during DRAIN -> drain counter frozen, done delayed 3 cycles.
REQ-026 rst pulsed during STREAM after 2 bases -> busy=0, init_out=0, ref_count=0 immediately; no done pulse.
REQ-027 start asserted while busy -> ignored; threshold_out unchanged; single done per alignment.
